dual_lane_mem_arbiter: RTL
==========================

Name: dual_lane_mem_arbiter

Overview:
Shares the single data-memory port between the two issue lanes of the 2-way superscalar core. LW/SW requests from both lanes in the same packet are serialized in program order, lane 0 first. When both lanes request in one cycle, the block stalls the front end for one cycle. Load results return to the register-file writeback path with their destination register and lane tag.

Parameters:
AW, 10, memory word-address width (1024-word data memory)
DW, 32, data width
RW, 5, register-index width
CNT_W, 16, width of saturating conflict counter

Ports:
clk1  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
l0_req  in  1  lane 0 memory op valid this cycle
l0_we  in  1  lane 0: 1=SW, 0=LW
l0_addr  in  AW  lane 0 effective address
l0_wdata  in  DW  lane 0 store data
l0_rd  in  RW  lane 0 load destination register
l1_req, l1_we, l1_addr, l1_wdata, l1_rd  in  1/1/AW/DW/RW  lane 1 equivalents
stall  out  1  front end must freeze; lane inputs not sampled while high
mem_en  out  1  memory access this cycle
mem_we  out  1  write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  read data, valid the cycle after mem_en with mem_we=0
wb_valid  out  1  load result valid
wb_rd  out  RW  load destination register
wb_data  out  DW  load data
wb_lane  out  1  lane that issued the load
conflict_cnt  out  CNT_W  count of dual-request cycles, saturating

Behaviour:
- Reset is synchronous, active-high. While reset is sampled high at an edge: state=IDLE, hold register cleared, in-flight load tracking cleared, and all outputs 0 (stall, mem_*, wb_*, conflict_cnt).
- A reset asserted mid-operation discards any held lane-1 request and any in-flight load; no wb_valid follows.
- All outputs are registered.
- Two-state FSM: IDLE, DEFER.
- IDLE, requests sampled at edge E0:
  - Neither lane requests: mem_en=0 in the next cycle.
  - Exactly one lane requests: its op drives mem_* in the cycle after E0; FSM stays in IDLE.
  - Both lanes request: lane 0 drives mem_* in the cycle after E0. Lane 1's op is latched into the hold register, the FSM goes to DEFER, stall=1 in the cycle after E0, and conflict_cnt increments, holding at 2^CNT_W-1 once saturated.
- DEFER:
  - Lane inputs are ignored.
  - At the next edge the held lane-1 op drives mem_*, stall returns to 0 and the FSM goes to IDLE.
  - The front end re-presents new ops only after stall drops.
- Ordering: lane 0 always accesses memory before lane 1 of the same packet. A same-address SW(l0) followed by LW(l1) therefore returns the stored data.
- Load pipeline:
  - A load issued with mem_en in cycle C1 has its rd and lane tracked.
  - mem_rdata is valid in C2 and registered at the end of C2.
  - wb_valid=1 in C3 with wb_rd, wb_data and wb_lane.
  - Request-to-writeback latency is 3 edges.
  - One load can complete per cycle, fully pipelined.
- Stores produce no wb_valid.
- mem_* are 0 (mem_en=0) in any cycle without an access. wb_* hold 0 when wb_valid=0.
- No special case for register 0: a load to register 0 is written back like any other.

Test Plan:
1. MEM[50]=100; l0 LW addr 50 rd=1 at E0 -> C1: mem_en=1, we=0, addr=50; C3: wb_valid=1, rd=1, data=100, lane=0; stall stays 0.
2. MEM[50]=100, MEM[40]=200; same-cycle l0 LW 50 rd=1 and l1 LW 40 rd=2 -> C1: mem addr 50 with stall=1; C2: addr 40 with stall=0; C3: wb rd=1 data=100 lane=0; C4: wb rd=2 data=200 lane=1; conflict_cnt=1.
3. l0 SW addr 80 wdata=7 and l1 LW addr 80 rd=3 in the same cycle -> C1: write to 80; C2: read of 80; wb rd=3 data=7 lane=1; no wb for the store.
4. Single lane-1 LW every cycle for 8 cycles, addrs 0..7 -> mem_en high 8 consecutive cycles, stall never high, 8 consecutive wb_valid pulses in order.
5. Dual request, then reset=1 during DEFER -> following cycle: mem_en=0, stall=0, conflict_cnt=0; no wb_valid for either load.
6. CNT_W=4; 20 dual-request packets each separated by the stall cycle -> conflict_cnt reaches 15 and holds at 15.

Source files
------------

// File: rtl/dual_lane_mem_arbiter.sv
// Two-lane data-memory arbiter: serialises same-packet LW/SW ops from the two
// issue lanes onto one memory port (lane 0 first) and returns load results to
// writeback tagged with destination register and issuing lane.
module dual_lane_mem_arbiter #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             l0_req,
  input  logic             l0_we,
  input  logic [AW-1:0]    l0_addr,
  input  logic [DW-1:0]    l0_wdata,
  input  logic [RW-1:0]    l0_rd,
  input  logic             l1_req,
  input  logic             l1_we,
  input  logic [AW-1:0]    l1_addr,
  input  logic [DW-1:0]    l1_wdata,
  input  logic [RW-1:0]    l1_rd,
  output logic             stall,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             wb_valid,
  output logic [RW-1:0]    wb_rd,
  output logic [DW-1:0]    wb_data,
  output logic             wb_lane,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    IDLE,
    DEFER
  } state_e;

  state_e           state_q, state_d;

  // Deferred lane-1 op (only meaningful while in DEFER)
  logic             hold_we_q, hold_we_d;
  logic [AW-1:0]    hold_addr_q, hold_addr_d;
  logic [DW-1:0]    hold_wdata_q, hold_wdata_d;
  logic [RW-1:0]    hold_rd_q, hold_rd_d;

  // Memory port and front-end stall
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load tracking: stage 1 = load on the port, stage 2 = read data arriving
  logic             ld1_valid_q, ld1_valid_d;
  logic [RW-1:0]    ld1_rd_q, ld1_rd_d;
  logic             ld1_lane_q, ld1_lane_d;
  logic             ld2_valid_q, ld2_valid_d;
  logic [RW-1:0]    ld2_rd_q, ld2_rd_d;
  logic             ld2_lane_q, ld2_lane_d;

  // Writeback outputs
  logic             wb_valid_q, wb_valid_d;
  logic [RW-1:0]    wb_rd_q, wb_rd_d;
  logic [DW-1:0]    wb_data_q, wb_data_d;
  logic             wb_lane_q, wb_lane_d;

  // Arbitration FSM: chooses the op for the memory port, defers lane 1 on conflict
  always_comb begin
    state_d      = state_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_rd_d    = hold_rd_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    stall_d      = 1'b0;
    cnt_d        = cnt_q;
    ld1_valid_d  = 1'b0;
    ld1_rd_d     = '0;
    ld1_lane_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (l0_req) begin
          mem_en_d   = 1'b1;
          mem_we_d   = l0_we;
          mem_addr_d = l0_addr;
          if (l0_we) begin
            mem_wdata_d = l0_wdata;
          end else begin
            ld1_valid_d = 1'b1;
            ld1_rd_d    = l0_rd;
            ld1_lane_d  = 1'b0;
          end
        end
        if (l1_req) begin
          if (l0_req) begin
            hold_we_d    = l1_we;
            hold_addr_d  = l1_addr;
            hold_wdata_d = l1_wdata;
            hold_rd_d    = l1_rd;
            state_d      = DEFER;
            stall_d      = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            mem_en_d   = 1'b1;
            mem_we_d   = l1_we;
            mem_addr_d = l1_addr;
            if (l1_we) begin
              mem_wdata_d = l1_wdata;
            end else begin
              ld1_valid_d = 1'b1;
              ld1_rd_d    = l1_rd;
              ld1_lane_d  = 1'b1;
            end
          end
        end
      end

      DEFER: begin
        mem_en_d   = 1'b1;
        mem_we_d   = hold_we_q;
        mem_addr_d = hold_addr_q;
        if (hold_we_q) begin
          mem_wdata_d = hold_wdata_q;
        end else begin
          ld1_valid_d = 1'b1;
          ld1_rd_d    = hold_rd_q;
          ld1_lane_d  = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load return pipeline: track the issued load, capture read data one cycle later
  always_comb begin
    ld2_valid_d = ld1_valid_q;
    ld2_rd_d    = ld1_rd_q;
    ld2_lane_d  = ld1_lane_q;
    wb_valid_d  = ld2_valid_q;
    wb_rd_d     = '0;
    wb_data_d   = '0;
    wb_lane_d   = 1'b0;
    if (ld2_valid_q) begin
      wb_rd_d   = ld2_rd_q;
      wb_data_d = mem_rdata;
      wb_lane_d = ld2_lane_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_rd_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      stall_q      <= 1'b0;
      cnt_q        <= '0;
      ld1_valid_q  <= 1'b0;
      ld1_rd_q     <= '0;
      ld1_lane_q   <= 1'b0;
      ld2_valid_q  <= 1'b0;
      ld2_rd_q     <= '0;
      ld2_lane_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_lane_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_rd_q    <= hold_rd_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      stall_q      <= stall_d;
      cnt_q        <= cnt_d;
      ld1_valid_q  <= ld1_valid_d;
      ld1_rd_q     <= ld1_rd_d;
      ld1_lane_q   <= ld1_lane_d;
      ld2_valid_q  <= ld2_valid_d;
      ld2_rd_q     <= ld2_rd_d;
      ld2_lane_q   <= ld2_lane_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_lane_q    <= wb_lane_d;
    end
  end

  assign stall        = stall_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_lane      = wb_lane_q;
  assign conflict_cnt = cnt_q;

endmodule
